data_memory_param: RTL
======================

Name: data_memory_param

Overview:
Parametrised single-port data memory, the successor to the fixed 64x16 data memory of the 16-bit RISC core.
- Adds configurable width and depth, byte-lane write enables, and a registered read with a valid strobe.
- Adds a hardware clear sequencer that zeroes the whole array after reset or on request.
- Sits between the core's memory stage and the register file write-back path.

Parameters:
DATA_W, 16, data word width in bits; must be a multiple of 8 and at least 8
ADDR_W, 6, address width; DEPTH = 2**ADDR_W words
BE_W, DATA_W/8, number of byte lanes (derived; not to be overridden)

Ports:
clk  in  1  single clock; all state updates on its rising edge
rst  in  1  synchronous, active-high reset
clr_req  in  1  request a full-array clear (sampled only while ready=1)
wr_en  in  1  write request
rd_en  in  1  read request
be  in  BE_W  byte-lane enables for writes; be[k] covers data_in[8k+7:8k]
addr  in  ADDR_W  word address for read and write
data_in  in  DATA_W  write data
data_out  out  DATA_W  registered read data; holds value until the next accepted read
rd_valid  out  1  one-cycle pulse, high the cycle data_out updates
ready  out  1  high when requests are accepted (state IDLE)
clr_done  out  1  one-cycle pulse on the first ready cycle after a clear

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=CLEAR, clr_ptr=0, data_out=0, rd_valid=0, ready=0, clr_done=0.
  - Reset asserted mid-clear or mid-operation restarts the clear from address 0.
- State CLEAR:
  - Each cycle writes mem[clr_ptr] with 0 (all lanes) and increments clr_ptr.
  - After writing address DEPTH-1, the next state is IDLE.
  - Clearing takes exactly DEPTH cycles; ready rises on cycle DEPTH after rst deasserts.
  - clr_done pulses high with that first ready cycle.
  - wr_en, rd_en and clr_req are ignored; rd_valid=0; data_out holds.
- State IDLE (ready=1):
  - Write (wr_en=1): each byte lane k with be[k]=1 takes data_in lane k; lanes with be[k]=0 keep their contents. be=0 is a legal no-op write.
  - Read (rd_en=1): data_out <= mem[addr] at the edge; rd_valid=1 for that one cycle, so latency is 1 cycle.
  - Read and write in the same cycle: both are performed. The read is read-first and returns the pre-write contents of addr.
  - clr_req=1: any wr/rd in the same cycle completes first; then state=CLEAR, clr_ptr=0 and ready=0 from the next cycle.
  - data_out is not zeroed by clr_req, only by rst.
- Address space: all ADDR_W values are valid, so there is no out-of-range case. clr_ptr wraps only via the state transition.
- Widths:
  - clr_ptr is ADDR_W bits.
  - Terminal detection is clr_ptr == DEPTH-1 (all ones); no extra counter bit.
- No reset of the array other than through the clear sequencer; the memory is inferred as a synchronous RAM plus clear write port mux.

Decomposition:
Shared package/header holds:
- State encoding constants ST_CLEAR=1'b0, ST_IDLE=1'b1.
- The byte-lane merge function (old word, new word, be -> merged word), reusable by the instruction memory successor.

One natural sub-module, data_memory_clear_seq:
- Owns the state register, clr_ptr, ready and clr_done.
- Drives a clear-write address/enable into the array mux.
- Top level keeps the array, read register and lane merge.

Test Plan:
1. Reset then idle (DATA_W=16, ADDR_W=6): rst high 2 cycles, then low -> ready=0 for 64 cycles, ready=1 and clr_done=1 on cycle 64, clr_done=0 on cycle 65; reading addr 0..63 returns 0x0000 each with rd_valid.
2. Byte lanes: write 0xABCD be=2'b11 at addr 5, then 0x12EF be=2'b01 at addr 5, read addr 5 -> data_out=0xABEF one cycle after rd_en, rd_valid pulse of width 1.
3. Simultaneous rd/wr: mem[9]=0x1111; same cycle wr_en=1 data_in=0x2222 be=2'b11 and rd_en=1 addr 9 -> data_out=0x1111; next read -> 0x2222.
4. Requests during clear: assert clr_req with write 0x5555 at addr 3 in the same cycle -> write lands, then 64 cycles ready=0; wr_en/rd_en pulsed during the clear have no effect and give rd_valid=0; read addr 3 afterwards -> 0x0000; data_out kept its pre-clear value until that read.
5. Reset mid-clear: assert clr_req, then rst at clear cycle 20 -> ready returns exactly 64 cycles after rst deasserts and data_out=0.
6. Parameter sweep DATA_W=32, ADDR_W=4: clear takes 16 cycles; write 0xDEADBEEF be=4'b1010 over 0 -> read returns 0xDE00BE00.

Source files
------------

// File: rtl/data_memory_param_pkg.sv
// Shared types and helpers for the parametrised data memory family.
// Holds the clear-sequencer state encoding and the byte-lane merge function.
package data_memory_param_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // Widest word the merge helper supports; callers zero-extend and truncate.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    function automatic logic [MAX_DATA_W-1:0] lane_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] merged;
        for (int k = 0; k < MAX_BE_W; k++) begin
            merged[8*k +: 8] = be[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_memory_param_if.sv
// Request/response bundle between the core memory stage and the data memory.
interface data_memory_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
);
    localparam int BE_W = DATA_W / 8;

    logic              clr_req;
    logic              wr_en;
    logic              rd_en;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              ready;
    logic              clr_done;

    modport master (
        output clr_req, wr_en, rd_en, be, addr, data_in,
        input  data_out, rd_valid, ready, clr_done
    );

    modport slave (
        input  clr_req, wr_en, rd_en, be, addr, data_in,
        output data_out, rd_valid, ready, clr_done
    );

endinterface

// File: rtl/data_memory_clear_seq.sv
// Clear sequencer: walks every address writing zero after reset or on request,
// then hands the array over to normal traffic (IDLE) with a one-cycle clr_done.
module data_memory_clear_seq
    import data_memory_param_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr_req,
    output logic              o_ready,
    output logic              o_clr_done,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] w_clr_ptr_nxt;
    logic              r_clr_done;
    logic              w_clr_done_nxt;
    logic              w_last;

    assign w_last = &r_clr_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_clr_ptr  <= '0;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_ptr  <= w_clr_ptr_nxt;
            r_clr_done <= w_clr_done_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_ptr_nxt  = r_clr_ptr;
        w_clr_done_nxt = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
                if (w_last) begin
                    w_state_nxt    = ST_IDLE;
                    w_clr_ptr_nxt  = '0;
                    w_clr_done_nxt = 1'b1;
                end
            end
            ST_IDLE: begin
                if (i_clr_req) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_ptr_nxt = '0;
                end
            end
        endcase
    end

    assign o_ready    = (r_state == ST_IDLE);
    assign o_clr_we   = (r_state == ST_CLEAR);
    assign o_clr_addr = r_clr_ptr;
    assign o_clr_done = r_clr_done;

endmodule

// File: rtl/data_memory_param.sv
// Parametrised single-port data memory with byte-lane writes, a registered
// read-first read port and a hardware clear sequencer.
module data_memory_param
    import data_memory_param_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int ADDR_W = 6,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic                clk,
    input  logic                rst,
    data_memory_param_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_data_out;
    logic              r_rd_valid;

    logic              w_ready;
    logic              w_clr_done;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic [BE_W-1:0]   w_be;
    logic [DATA_W-1:0] w_old_word;
    logic [DATA_W-1:0] w_merged;
    logic              w_wr_fire;
    logic              w_rd_fire;

    data_memory_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .i_clr_req  (bus.clr_req),
        .o_ready    (w_ready),
        .o_clr_done (w_clr_done),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    // Requests only take effect while the sequencer has handed over the array.
    assign w_wr_fire  = w_ready & bus.wr_en & ~rst;
    assign w_rd_fire  = w_ready & bus.rd_en;
    assign w_be       = bus.be;
    assign w_old_word = r_mem[bus.addr];
    assign w_merged   = DATA_W'(lane_merge(MAX_DATA_W'(w_old_word),
                                           MAX_DATA_W'(bus.data_in),
                                           MAX_BE_W'(w_be)));

    // NOTE: the array has no reset branch; it is zeroed only by the clear
    // sequencer, which keeps it mappable onto a plain synchronous RAM.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_fire) begin
            r_mem[bus.addr] <= w_merged;
        end
    end

    // Reads sample the array before this edge's write, giving read-first data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_data_out <= r_mem[bus.addr];
            end
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.rd_valid = r_rd_valid;
    assign bus.ready    = w_ready;
    assign bus.clr_done = w_clr_done;

endmodule
